// File: rtl/mac_result_checker.sv
// Compares DUT MAC results against a FIFO of expected values and tallies pass/fail.
// Optional macro CHK_TOL_EN: accept a 1-ULP magnitude difference with matching sign.
module mac_result_checker #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [10:0]  cnt,
  input  logic         exp_valid,
  input  logic [W-1:0] exp_mac,
  input  logic         dut_valid,
  input  logic [W-1:0] dut_mac,
  output logic         exp_ready,
  output logic         busy,
  output logic         done,
  output logic [10:0]  pass_cnt,
  output logic [10:0]  fail_cnt,
  output logic         err_ovf,
  output logic         err_unf,
  output logic [10:0]  ff_idx,
  output logic [W-1:0] ff_got,
  output logic [W-1:0] ff_exp
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [10:0]   cnt_q, idx;
  logic          in_run, full, empty, go;
  logic          pop, push, bypass, ovf, unf, cmp, match, last;
  logic [W-1:0]  expected;

  assign in_run    = (state == RUN);
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign go        = start && (state != RUN);

  // An empty FIFO with both valids compares straight through and leaves the FIFO alone.
  assign bypass    = in_run && dut_valid && exp_valid && empty;
  assign pop       = in_run && dut_valid && !empty;
  assign push      = in_run && exp_valid && !bypass && (!full || pop);
  assign ovf       = in_run && exp_valid && full && !pop;
  assign unf       = in_run && dut_valid && empty && !exp_valid;
  assign cmp       = pop || bypass;
  assign expected  = bypass ? exp_mac : mem[rd_ptr];
  assign last      = cmp && (idx == cnt_q);

  assign exp_ready = !full;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

`ifdef CHK_TOL_EN
  logic [W-1:0] mag_diff;

  // Zero-extended subtraction so -1 is all ones and cannot alias a large wrap.
  assign mag_diff = {1'b0, dut_mac[W-2:0]} - {1'b0, expected[W-2:0]};
  assign match    = (dut_mac == expected) ||
                    ((dut_mac[W-1] == expected[W-1]) &&
                     ((mag_diff == W'(1)) || (mag_diff == '1)));
`else
  assign match    = (dut_mac == expected);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (last)  state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cnt_q    <= '0;
      idx      <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_ovf  <= 1'b0;
      err_unf  <= 1'b0;
      ff_idx   <= '0;
      ff_got   <= '0;
      ff_exp   <= '0;
    end else begin
      state <= state_nxt;
      if (go) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        cnt_q    <= cnt;
        idx      <= '0;
        pass_cnt <= '0;
        fail_cnt <= '0;
        err_ovf  <= 1'b0;
        err_unf  <= 1'b0;
        ff_idx   <= '0;
        ff_got   <= '0;
        ff_exp   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        if (ovf) err_ovf <= 1'b1;
        if (unf) err_unf <= 1'b1;
        // Tallies saturate; fail_cnt still at zero marks the first failure of the run.
        if (cmp) begin
          if (match) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
          end else begin
            if (fail_cnt == '0) begin
              ff_idx <= idx;
              ff_got <= dut_mac;
              ff_exp <= expected;
            end
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          end
          if (idx != '1) idx <= idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= exp_mac;
  end

endmodule

// File: tb/tb_mac_result_checker.sv
// Scoreboard bench for mac_result_checker: a queue-based model predicts each run's
// final tallies, and a monitor compares them when done rises.
module tb_mac_result_checker;

  localparam int DEPTH = 8;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [10:0]  cnt = '0;
  logic         exp_valid = 1'b0;
  logic [W-1:0] exp_mac = '0;
  logic         dut_valid = 1'b0;
  logic [W-1:0] dut_mac = '0;
  logic         exp_ready, busy, done, err_ovf, err_unf;
  logic [10:0]  pass_cnt, fail_cnt, ff_idx;
  logic [W-1:0] ff_got, ff_exp;

  always #5 clk = ~clk;

  mac_result_checker #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cnt(cnt),
    .exp_valid(exp_valid), .exp_mac(exp_mac),
    .dut_valid(dut_valid), .dut_mac(dut_mac),
    .exp_ready(exp_ready), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_ovf(err_ovf), .err_unf(err_unf),
    .ff_idx(ff_idx), .ff_got(ff_got), .ff_exp(ff_exp)
  );

  typedef struct {
    int           pass;
    int           fail;
    bit           ovf;
    bit           unf;
    int           ff_idx;
    logic [W-1:0] ff_got;
    logic [W-1:0] ff_exp;
  } res_t;

  res_t         sb_q[$];
  int           checks = 0;
  int           failures = 0;

  logic [W-1:0] m_q[$];
  res_t         m;
  int           m_idx;
  int           m_cnt;
  bit           m_done;

  task automatic check_output(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, act, req);
    end
  endtask

  function automatic bit results_agree(logic [W-1:0] got, logic [W-1:0] want);
`ifdef CHK_TOL_EN
    longint d;
    d = longint'(got[W-2:0]) - longint'(want[W-2:0]);
    return (got == want) || ((got[W-1] == want[W-1]) && (d == 1 || d == -1));
`else
    return got == want;
`endif
  endfunction

  function automatic void model_reset(int c);
    m_q.delete();
    m = '{default: 0};
    m_idx = 0;
    m_cnt = c;
    m_done = 0;
  endfunction

  // One clock of stimulus applied to the reference model.
  function automatic void model_step(bit ev, logic [W-1:0] em, bit dv, logic [W-1:0] dm);
    logic [W-1:0] want;
    bit           compared;
    compared = 0;
    want = '0;
    if (m_done) return;
    if (dv && m_q.size() > 0) begin
      want = m_q.pop_front();
      compared = 1;
      if (ev) m_q.push_back(em);
    end else if (dv && ev) begin
      want = em;
      compared = 1;
    end else if (dv) begin
      m.unf = 1;
    end else if (ev) begin
      if (m_q.size() < DEPTH) m_q.push_back(em);
      else m.ovf = 1;
    end
    if (compared) begin
      if (results_agree(dm, want)) m.pass++;
      else begin
        if (m.fail == 0) begin
          m.ff_idx = m_idx;
          m.ff_got = dm;
          m.ff_exp = want;
        end
        m.fail++;
      end
      if (m_idx == m_cnt) begin
        m_done = 1;
        sb_q.push_back(m);
      end
      m_idx++;
    end
  endfunction

  always @(negedge clk) begin : monitor
    res_t e;
    bit   done_prev;
    if (done && !done_prev) begin
      check_output("sb_entry", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_output("pass_cnt", pass_cnt, e.pass);
        check_output("fail_cnt", fail_cnt, e.fail);
        check_output("err_ovf", err_ovf, e.ovf);
        check_output("err_unf", err_unf, e.unf);
        check_output("ff_idx", ff_idx, e.ff_idx);
        check_output("ff_got", ff_got, e.ff_got);
        check_output("ff_exp", ff_exp, e.ff_exp);
      end
    end
    done_prev = done;
  end

  task automatic apply_stimulus(bit ev, logic [W-1:0] em, bit dv, logic [W-1:0] dm);
    exp_valid = ev;
    exp_mac   = em;
    dut_valid = dv;
    dut_mac   = dm;
    model_step(ev, em, dv, dm);
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    dut_valid = 1'b0;
    check_output("exp_ready", exp_ready, m_q.size() < DEPTH);
    check_output("busy", busy, !m_done);
  endtask

  task automatic start_run(int c);
    cnt   = 11'(c);
    start = 1'b1;
    model_reset(c);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("start_busy", busy, 1);
    check_output("start_pass_clr", pass_cnt, 0);
    check_output("start_unf_clr", err_unf, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("done_timeout", done, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic random_run(int c);
    int           guard = 0;
    logic [W-1:0] e, h, d;
    bit           ev, dv;
    start_run(c);
    while (!m_done && guard < 2000) begin
      ev = ($urandom_range(0, 99) < 55);
      dv = ($urandom_range(0, 99) < 45);
      e  = $urandom();
      h  = (m_q.size() > 0) ? m_q[0] : e;
      case ($urandom_range(0, 5))
        0:       d = $urandom();
        1:       d = {h[W-1], h[W-2:0] + 1'b1};
        2:       d = {h[W-1], h[W-2:0] - 1'b1};
        3:       d = {~h[W-1], h[W-2:0]};
        default: d = h;
      endcase
      apply_stimulus(ev, e, dv, d);
      guard++;
    end
    wait_done();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] v;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_ready", exp_ready, 1);
    check_output("rst_pass", pass_cnt, 0);
    check_output("rst_fail", fail_cnt, 0);
    check_output("rst_flags", {err_ovf, err_unf}, 0);
    check_output("rst_ff", {ff_idx, ff_got, ff_exp}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four expected values, then four matching results.
    start_run(3);
    for (int i = 0; i < 4; i++) apply_stimulus(1, $urandom(), 0, '0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, '0, 1, m_q[0]);
    wait_done();
    check_output("basic_pass", pass_cnt, 4);
    check_output("basic_fail", fail_cnt, 0);
    check_output("basic_done", done, 1);
    check_output("basic_err", {err_ovf, err_unf}, 0);

    // Off-by-one-ULP result at index 1.
    start_run(2);
    apply_stimulus(1, 32'h3F80_0000, 0, '0);
    apply_stimulus(1, 32'h4000_0000, 0, '0);
    apply_stimulus(1, 32'h4040_0000, 0, '0);
    apply_stimulus(0, '0, 1, 32'h3F80_0000);
    apply_stimulus(0, '0, 1, 32'h4000_0001);
    apply_stimulus(0, '0, 1, 32'h4040_0000);
    wait_done();
`ifdef CHK_TOL_EN
    check_output("ulp_pass", pass_cnt, 3);
`else
    check_output("ulp_fail", fail_cnt, 1);
    check_output("ulp_ff_idx", ff_idx, 1);
    check_output("ulp_ff_got", ff_got, 32'h4000_0001);
    check_output("ulp_ff_exp", ff_exp, 32'h4000_0000);
`endif

    // Overfill the FIFO, then drain it.
    start_run(7);
    for (int i = 0; i < 9; i++) apply_stimulus(1, $urandom(), 0, '0);
    check_output("ovf_ready", exp_ready, 0);
    check_output("ovf_flag", err_ovf, 1);
    for (int i = 0; i < 8; i++) apply_stimulus(0, '0, 1, m_q[0]);
    wait_done();

    // Underflow, then a bypass compare on an empty FIFO.
    start_run(0);
    apply_stimulus(0, '0, 1, $urandom());
    check_output("unf_flag", err_unf, 1);
    check_output("unf_counts", {pass_cnt, fail_cnt}, 0);
    apply_stimulus(1, 32'h1234_5678, 1, 32'h1234_5678);
    wait_done();
    check_output("bypass_pass", pass_cnt, 1);

    // Asynchronous reset in the middle of a run.
    start_run(4);
    for (int i = 0; i < 5; i++) apply_stimulus(1, $urandom(), 0, '0);
    for (int i = 0; i < 2; i++) apply_stimulus(0, '0, 1, m_q[0]);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_counts", {pass_cnt, fail_cnt}, 0);
    check_output("mid_rst_ready", exp_ready, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    start_run(1);
    v = $urandom();
    apply_stimulus(1, v, 0, '0);
    apply_stimulus(1, v ^ 32'h00F0_0000, 1, v);
    apply_stimulus(0, '0, 1, v ^ 32'h00F0_0000);
    wait_done();
    check_output("post_rst_pass", pass_cnt, 2);

    for (int r = 0; r < 6; r++) random_run($urandom_range(0, 12));

    check_output("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_result_checker.md
MAC_RESULT_CHECKER -- requirements
Module: mac_result_checker

Interface
REQ-001 Parameter DEPTH, default 8, expected-value FIFO depth (power of two, 2..64).
REQ-002 Parameter W, default 32, result width in bits.
REQ-003 CLK  in  1  sole clock, all state updates on rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse that begins a check run.
REQ-006 cnt  in  11  index of the last vector; a run checks cnt+1 results.
REQ-007 exp_valid  in  1  expected result present on exp_mac.
REQ-008 exp_mac  in  W  expected MAC result from the stimulus source.
REQ-009 dut_valid  in  1  DUT result present on dut_mac.
REQ-010 dut_mac  in  W  MAC result from the DUT.
REQ-011 exp_ready  out  1  FIFO not full.
REQ-012 busy  out  1  high in RUN.
REQ-013 done  out  1  high in DONE.
REQ-014 pass_cnt, fail_cnt  out  11 each  compare tallies.
REQ-015 err_ovf, err_unf  out  1 each  sticky FIFO overflow/underflow flags.
REQ-016 ff_idx  out  11, ff_got  out  W, ff_exp  out  W  first-failure capture.

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on start; DONE->RUN on start; start ignored in RUN.
REQ-018 On start: clear pass_cnt, fail_cnt, err flags, ff_* and FIFO; latch cnt; idx counter = 0.
REQ-019 Inputs exp_valid and dut_valid are ignored outside RUN.
REQ-020 In RUN, exp_valid with FIFO not full pushes exp_mac.
REQ-021 In RUN, dut_valid with FIFO non-empty pops the head and compares it with dut_mac in the same cycle.
REQ-022 Push and pop in the same cycle are both honoured, including when the FIFO is full.
REQ-023 dut_valid and exp_valid in the same cycle with an empty FIFO: dut_mac is compared directly against exp_mac (bypass), and the FIFO stays unchanged.
REQ-024 exp_valid with FIFO full and no pop: value dropped, err_ovf set.
REQ-025 dut_valid with FIFO empty and no exp_valid: no compare, err_unf set, idx unchanged.
REQ-026 Each compare increments pass_cnt on match, else fail_cnt, then increments idx.
REQ-027 On the first failure of a run, capture ff_idx=idx, ff_got=dut_mac, ff_exp=expected; hold until next start.
REQ-028 RUN->DONE in the cycle after the compare with idx==latched cnt; done asserts one cycle after that compare.
REQ-029 Counters are 11-bit and saturate at 2047, with no wrap.
REQ-030 Outputs are registered; pass_cnt/fail_cnt reflect a compare one cycle after it.

Reset
REQ-031 RST_N low asynchronously forces IDLE, empties the FIFO, and drives all outputs to 0 except exp_ready=1.
REQ-032 Reset mid-run discards all state; a fresh start is required after release.

Configuration
REQ-033 Macro CHK_TOL_EN defined: a compare passes when the bit patterns are equal, or when the sign bits are equal and the unsigned magnitude fields differ by exactly 1 (1-ULP tolerance).
REQ-034 CHK_TOL_EN undefined: a compare passes only on exact W-bit equality.

Verification
REQ-035 Reset, start with cnt=3; push 4 expected values, then 4 matching dut values -> pass_cnt=4, fail_cnt=0, done=1, errors 0.
REQ-036 cnt=2; expected {0x3F800000, 0x40000000, 0x40400000}; dut {0x3F800000, 0x40000001, 0x40400000} -> without CHK_TOL_EN: fail_cnt=1, ff_idx=1, ff_got=0x40000001, ff_exp=0x40000000; with it: pass_cnt=3.
REQ-037 DEPTH=8; push 9 expected values with no dut_valid -> exp_ready=0 after 8, err_ovf=1.
REQ-038 dut_valid with FIFO empty and no exp_valid -> err_unf=1, pass_cnt=fail_cnt=0; simultaneous exp_valid and dut_valid (both 0x12345678) on empty FIFO -> pass_cnt=1.
REQ-039 Assert RST_N low after 2 of 5 compares -> immediately IDLE, counts 0, exp_ready=1; a new start then runs cleanly.
